// File: rtl/data_mem.sv
// data_mem: dual-port synchronous data memory with byte enables,
// write-first bypass and a sequential clear sequencer.
module data_mem #(
    parameter int                AWIDTH   = 8,
    parameter int                DWIDTH   = 16,
    parameter logic [DWIDTH-1:0] INIT_VAL = {DWIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd,
    input  logic                  i_wr,
    input  logic [AWIDTH-1:0]     i_raddr,
    input  logic [AWIDTH-1:0]     i_waddr,
    input  logic [DWIDTH-1:0]     i_wdata,
    input  logic [DWIDTH/8-1:0]   i_be,
    input  logic                  i_clr,
    output logic [DWIDTH-1:0]     o_rdata,
    output logic                  o_rvalid,
    output logic                  o_busy
);

    localparam int NB    = DWIDTH / 8;
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t             state;
    logic [AWIDTH-1:0]  cnt;
    logic [DWIDTH-1:0]  mem [DEPTH];
    logic [DWIDTH-1:0]  rd_word;

    // Write-first: enabled bytes of a same-address write override the old word
    always_comb begin
        rd_word = mem[i_raddr];
        if (i_wr && (i_waddr == i_raddr)) begin
            for (int k = 0; k < NB; k++) begin
                if (i_be[k]) begin
                    rd_word[8*k +: 8] = i_wdata[8*k +: 8];
                end
            end
        end
    end

    // Array has no reset; writes are suppressed while rst is held low
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= INIT_VAL;
            end else if (i_wr) begin
                for (int k = 0; k < NB; k++) begin
                    if (i_be[k]) begin
                        mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            o_busy   <= 1'b1;
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    o_rdata  <= '0;
                    o_rvalid <= 1'b0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == {AWIDTH{1'b1}}) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                IDLE: begin
                    o_rvalid <= i_rd;
                    o_rdata  <= i_rd ? rd_word : '0;
                    if (i_clr) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
